light_arbiter_timed: RTL and testbench

- Timed two-way arbiter for the shared crossing resource, with requesters N (north) and E (east).
- Turns level requests cn/ce into per-direction green/yellow/red signals.
- Enforces minimum and maximum green, a yellow phase, an all-red clearance, and least-recently-served fairness.
- Safety properties: never both directions non-red; a green direction always implies red on the other.

---
 rtl/light_arb_pkg.sv | 59 +++++
 rtl/light_arbiter_timed_phase_timer.sv | 21 ++
 rtl/light_arbiter_timed.sv | 132 +++++++++++++
 tb/tb_light_arbiter_timed.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/light_arb_pkg.sv
// Shared types for the timed two-way crossing arbiter: phase encoding,
// direction type and the phase-to-lights decode.
package light_arb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GN    = 3'd1,
      YN    = 3'd2,
      CLR_N = 3'd3,
      GE    = 3'd4,
      YE    = 3'd5,
      CLR_E = 3'd6
   } phase_t;

   typedef enum logic {
      DIR_N = 1'b0,
      DIR_E = 1'b1
   } dir_t;

   typedef struct packed {
      logic gn;
      logic yn;
      logic rn;
      logic ge;
      logic ye;
      logic re;
   } lights_t;

   // Anything that is not a green or yellow phase (including the illegal
   // encoding) shows red both ways, so a corrupted state is still safe.
   function automatic lights_t decode_lights(input phase_t p);
      lights_t l;
      l = '0;
      case (p)
         GN: begin
            l.gn = 1'b1;
            l.re = 1'b1;
         end
         YN: begin
            l.yn = 1'b1;
            l.re = 1'b1;
         end
         GE: begin
            l.ge = 1'b1;
            l.rn = 1'b1;
         end
         YE: begin
            l.ye = 1'b1;
            l.rn = 1'b1;
         end
         default: begin
            l.rn = 1'b1;
            l.re = 1'b1;
         end
      endcase
      return l;
   endfunction

endpackage

// File: rtl/light_arbiter_timed_phase_timer.sv
// Saturating phase timer: reads 1 in the first cycle of a phase and counts
// up by one per cycle, sticking at all-ones.
module phase_timer #(
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   output logic [CW-1:0] count
);

   // Reload to 1 on reset or phase change, otherwise count up with saturation.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         count <= CW'(1);
      end else if (count != {CW{1'b1}}) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/light_arbiter_timed.sv
// Timed two-way arbiter for the shared crossing: turns level requests into
// green/yellow/red per direction with min/max green, yellow, all-red
// clearance and least-recently-served tie breaking.
module light_arbiter_timed
   import light_arb_pkg::*;
#(
   parameter int MIN_GREEN = 4,
   parameter int MAX_GREEN = 16,
   parameter int YELLOW    = 2,
   parameter int ALLRED    = 1,
   parameter int CW        = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cn,
   input  logic       ce,
   output logic       gn,
   output logic       yn,
   output logic       rn,
   output logic       ge,
   output logic       ye,
   output logic       re,
   output logic [2:0] phase
);

   localparam logic [CW-1:0] MIN_T = CW'(MIN_GREEN);
   localparam logic [CW-1:0] MAX_T = CW'(MAX_GREEN);
   localparam logic [CW-1:0] YEL_T = CW'(YELLOW);
   localparam logic [CW-1:0] CLR_T = CW'(ALLRED);

   phase_t        state;
   phase_t        next_state;
   dir_t          last_served;
   logic [CW-1:0] timer;
   logic          state_change;
   lights_t       lights;

   assign state_change = (next_state != state);

   phase_timer #(.CW(CW)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (state_change),
      .count (timer)
   );

   // State register and last-served pointer; reset aborts any phase to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_served <= DIR_E;
      end else begin
         state <= next_state;
         if (next_state == GN && state != GN) begin
            last_served <= DIR_N;
         end else if (next_state == GE && state != GE) begin
            last_served <= DIR_E;
         end
      end
   end

   // Next-phase selection from the current phase, its timer and the requests.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (cn && (!ce || last_served == DIR_E)) begin
               next_state = GN;
            end else if (ce) begin
               next_state = GE;
            end
         end
         GN: begin
            if ((timer >= MIN_T && !cn) || (timer >= MAX_T && ce)) begin
               next_state = YN;
            end
         end
         YN: begin
            if (timer >= YEL_T) begin
               next_state = CLR_N;
            end
         end
         CLR_N: begin
            if (timer >= CLR_T) begin
               if (ce) begin
                  next_state = GE;
               end else if (cn) begin
                  next_state = GN;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         GE: begin
            if ((timer >= MIN_T && !ce) || (timer >= MAX_T && cn)) begin
               next_state = YE;
            end
         end
         YE: begin
            if (timer >= YEL_T) begin
               next_state = CLR_E;
            end
         end
         CLR_E: begin
            if (timer >= CLR_T) begin
               if (cn) begin
                  next_state = GN;
               end else if (ce) begin
                  next_state = GE;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Moore outputs decoded from the state register only.
   always_comb begin
      lights = decode_lights(state);
   end

   assign gn    = lights.gn;
   assign yn    = lights.yn;
   assign rn    = lights.rn;
   assign ge    = lights.ge;
   assign ye    = lights.ye;
   assign re    = lights.re;
   assign phase = state;

endmodule

// File: tb/tb_light_arbiter_timed.sv
// Directed bench for light_arbiter_timed with a closing random-request run
// checked against the lighting invariants.
module tb_light_arbiter_timed;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cn = 1'b0;
   logic       ce = 1'b0;
   logic       gn, yn, rn, ge, ye, re;
   logic [2:0] phase;
   logic [5:0] lights;

   int n_tests = 0;
   int n_fail  = 0;

   light_arbiter_timed dut (
      .clk   (clk),
      .rst   (rst),
      .cn    (cn),
      .ce    (ce),
      .gn    (gn),
      .yn    (yn),
      .rn    (rn),
      .ge    (ge),
      .ye    (ye),
      .re    (re),
      .phase (phase)
   );

   assign lights = {gn, yn, rn, ge, ye, re};

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one cycle; outputs are read 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] lights_of(input int p);
      case (p)
         1: return 6'b100001;
         2: return 6'b010001;
         4: return 6'b001100;
         5: return 6'b001010;
         default: return 6'b001001;
      endcase
   endfunction

   task automatic expect_phase(input string tag, input int p);
      check_val(tag, 32'(phase), 32'(p));
      check_val({tag, "_lights"}, 32'(lights), 32'(lights_of(p)));
   endtask

   initial begin
      int seg_len[6];
      int seg_ph[6];
      int glen[2];
      int ylen[2];
      int allred_run;
      bit after_yellow;
      bit found;
      logic [1:0] g_now;
      logic [1:0] y_now;

      seg_len = '{16, 2, 1, 16, 2, 1};
      seg_ph  = '{1, 2, 3, 4, 5, 6};

      // 1. reset and idle
      tick();
      tick();
      expect_phase("reset", 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         expect_phase("idle", 0);
      end

      // 2. held N request, cn high for 10 cycles
      cn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 10) cn = 1'b0;
         expect_phase("held_gn", 1);
      end
      tick(); expect_phase("held_yn1", 2);
      tick(); expect_phase("held_yn2", 2);
      tick(); expect_phase("held_clr", 3);
      tick(); expect_phase("held_idle", 0);

      // 3. one-cycle pulse gives minimum green
      cn = 1'b1;
      tick();
      cn = 1'b0;
      expect_phase("pulse_gn1", 1);
      for (int i = 2; i <= 4; i++) begin
         tick();
         expect_phase("pulse_gn", 1);
      end
      tick(); expect_phase("pulse_yn1", 2);
      tick(); expect_phase("pulse_yn2", 2);
      tick(); expect_phase("pulse_clr", 3);
      tick(); expect_phase("pulse_idle", 0);

      // 4. both held after reset: N first, 38-cycle rotation
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cn = 1'b1;
      ce = 1'b1;
      for (int per = 0; per < 2; per++) begin
         for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < seg_len[s]; k++) begin
               tick();
               expect_phase("rotate", seg_ph[s]);
            end
         end
      end

      // 5. late opposite request forces change only at max green
      rst = 1'b1;
      ce = 1'b0;
      tick();
      rst = 1'b0;
      cn = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 10) ce = 1'b1;
         expect_phase("late_gn", 1);
      end
      tick(); expect_phase("late_yn1", 2);
      tick(); expect_phase("late_yn2", 2);
      tick(); expect_phase("late_clr", 3);
      tick(); expect_phase("late_ge", 4);

      // 6. reset during YE, then last-served reset lets N win the tie
      ce = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (phase == 3'd5) found = 1'b1;
      end
      check_val("reach_ye", 32'(found), 32'd1);
      rst = 1'b1;
      tick();
      expect_phase("rst_mid_ye", 0);
      rst = 1'b0;
      cn = 1'b1;
      ce = 1'b1;
      tick();
      expect_phase("tie_after_rst", 1);

      // random stress with invariant tracking
      glen[0] = gn ? 1 : 0;
      glen[1] = 0;
      ylen[0] = 0;
      ylen[1] = 0;
      allred_run = 0;
      after_yellow = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         cn = ($urandom_range(0, 7) < 3);
         ce = ($urandom_range(0, 7) < 3);
         tick();
         check_val("phase_legal", 32'(phase <= 3'd6), 32'd1);
         check_val("onehot_n", 32'($onehot({gn, yn, rn})), 32'd1);
         check_val("onehot_e", 32'($onehot({ge, ye, re})), 32'd1);
         check_val("n_implies_re", 32'(!(gn || yn) || re), 32'd1);
         check_val("e_implies_rn", 32'(!(ge || ye) || rn), 32'd1);
         check_val("no_dual_green", 32'(gn && ge), 32'd0);
         g_now = {ge, gn};
         y_now = {ye, yn};
         for (int d = 0; d < 2; d++) begin
            if (g_now[d]) begin
               glen[d]++;
               if (glen[d] == 1 && after_yellow) begin
                  check_val("clearance", 32'(allred_run >= 1), 32'd1);
                  after_yellow = 1'b0;
               end
            end else if (glen[d] > 0) begin
               check_val("green_len", 32'(glen[d] >= 4), 32'd1);
               glen[d] = 0;
            end
            if (y_now[d]) begin
               ylen[d]++;
            end else if (ylen[d] > 0) begin
               check_val("yellow_len", 32'(ylen[d]), 32'd2);
               ylen[d] = 0;
               after_yellow = 1'b1;
            end
         end
         if (rn && re) allred_run++;
         else allred_run = 0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
